updown_counter_ctrl: RTL and testbench
======================================

Name: updown_counter_ctrl

Overview:
Parametrised up/down counter with built-in clock prescaler, for driving LED banks and feeding debug-core probes.
Adds run enable, parallel load, selectable wrap/saturate mode and a wrap/limit pulse to the earlier fixed 6-bit divide-by-7 counter.
Keeps the debug-override pair inputs: vrst forces a soft clear, vdir forces the direction.
Sits between the board clock and the LED/probe wiring; all logic runs on a single clock domain.

Parameters:
WIDTH, 6, counter width in bits (legal range 2..32)
DIV, 7, prescaler ratio; one count step every DIV clocks (legal range 1..65535)
SAT, 0, 0 = wrap-around at the limits, 1 = saturate at 0 and at 2^WIDTH-1

Ports:
clock  input  1  system clock (50 MHz board oscillator)
rst_n  input  1  asynchronous reset, active low
en  input  1  run enable; when low, prescaler and count both hold
dir  input  1  count direction; 1 = up, 0 = down
vrst  input  2  debug soft-clear request; active only when equal to 2'b11
vdir  input  2  debug direction override; 2'b11 forces up
load  input  1  synchronous parallel load strobe
load_val  input  WIDTH  value loaded into the counter
count  output  WIDTH  current count (registered)
tick  output  1  prescaler terminal (combinational): pre==DIV-1 && en
wrap  output  1  one-clock pulse (registered) on a wrap step or a blocked saturate step

Behaviour:
- Interface: one clock, `clock`; reset `rst_n` is asynchronous, active-low. Assertion clears pre, count and wrap to 0 immediately, regardless of the clock.
- Prescaler `pre`: width is clog2(DIV), minimum 1 bit.
  - Counts 0..DIV-1 while en=1, then returns to 0.
  - Holds its value while en=0.
  - With DIV=1, tick equals en on every cycle.
- Effective direction: up = dir | (vdir==2'b11).
- Soft clear: soft_clr = (vrst==2'b11).
- Priority at each rising edge:
  1. soft_clr: count<=0, pre<=0, wrap<=0.
  2. load: count<=load_val, pre<=0, wrap<=0. Load ignores en and tick.
  3. tick: count steps by ±1 in the effective direction; wrap is set as below.
  4. Otherwise count holds and wrap<=0.
- Step rules with SAT=0:
  - Up from 2^WIDTH-1 gives 0, with wrap<=1.
  - Down from 0 gives 2^WIDTH-1, with wrap<=1.
  - All other steps leave wrap<=0.
- Step rules with SAT=1:
  - Up at 2^WIDTH-1 holds, with wrap<=1.
  - Down at 0 holds, with wrap<=1.
  - A pulse is raised on every blocked tick.
- Latency:
  - count changes on the same edge where tick=1.
  - wrap is high for exactly the clock following that edge.
  - First step after reset release occurs DIV clocks after the first en=1 cycle.
- Direction change mid-period takes effect on the next tick; the prescaler is not disturbed.
- Arithmetic is modulo 2^WIDTH. load_val is used as-is, with no range check.
- Soft clear and load asserted in the same cycle: soft clear wins.
- rst_n deasserted mid-period: the prescaler restarts from 0.

Optional Feature:
Macro: COUNT_SNAPSHOT_EN.
- Defined:
  - Adds input `snap` (1 bit) and output `snap_val` (WIDTH bits).
  - A 2-flop rising-edge detector on snap latches count into snap_val; latency is 2 clocks from snap going high.
  - snap_val resets to 0 on rst_n and on soft_clr.
- Not defined: neither port exists and no snapshot logic is built.

Test Plan:
- Reset then en=1, dir=1, WIDTH=6, DIV=7: tick every 7th clock; count=1 after 7 clocks and count=5 after 35 clocks; wrap stays 0.
- SAT=0, load_val=63 loaded, dir=1, en=1: next tick gives count=0 and a one-clock wrap pulse; dir=0 from 0 then gives 63 with a wrap pulse.
- SAT=1, count=63, dir=1: three ticks leave count at 63 with three separate wrap pulses; at 0 with dir=0, count holds at 0 and wrap pulses.
- dir=0, vdir=2'b11: count increments; vdir=2'b10: count decrements.
- count=20, then vrst=2'b11 together with load=1, load_val=9: count=0 and pre=0 next edge. vrst=2'b01 has no effect.
- rst_n pulsed low mid-period, between clock edges: count=0 immediately. With en=0, count and pre hold for 100 clocks. With COUNT_SNAPSHOT_EN, a snap edge at count=12 gives snap_val=12 two clocks later.

Source files
------------

// File: rtl/updown_counter_ctrl.sv
// Up/down counter with clock prescaler, run enable, parallel load, wrap/saturate mode and
// debug overrides. Optional count snapshot port is built when COUNT_SNAPSHOT_EN is defined.
module updown_counter_ctrl #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned DIV   = 7,
  parameter int unsigned SAT   = 0
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             en,
  input  logic             dir,
  input  logic [1:0]       vrst,
  input  logic [1:0]       vdir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`ifdef COUNT_SNAPSHOT_EN
  input  logic             snap,
  output logic [WIDTH-1:0] snap_val,
`endif
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             wrap
);

  localparam int unsigned     PreW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PreW-1:0] PreMax   = PreW'(DIV - 1);
  localparam logic [PreW-1:0] PreOne   = PreW'(1);
  localparam logic [WIDTH-1:0] CntMax  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CntOne  = WIDTH'(1);
  localparam bit              Saturate = (SAT != 0);

  logic [PreW-1:0]  r_pre;
  logic [PreW-1:0]  w_pre_d;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_d;
  logic             r_wrap;
  logic             w_wrap_d;

  logic w_up;
  logic w_soft_clr;
  logic w_tick;
  logic w_at_limit;

  assign w_up       = dir | (vdir == 2'b11);
  assign w_soft_clr = (vrst == 2'b11);
  assign w_tick     = en && (r_pre == PreMax);
  // Limit in the direction of travel: the step that would leave the range.
  assign w_at_limit = w_up ? (r_count == CntMax) : (r_count == '0);

  always_comb begin
    w_pre_d   = r_pre;
    w_count_d = r_count;
    w_wrap_d  = 1'b0;
    if (w_soft_clr) begin
      w_pre_d   = '0;
      w_count_d = '0;
    end else if (load) begin
      w_pre_d   = '0;
      w_count_d = load_val;
    end else if (w_tick) begin
      w_pre_d  = '0;
      w_wrap_d = w_at_limit;
      if (!(Saturate && w_at_limit)) begin
        w_count_d = w_up ? (r_count + CntOne) : (r_count - CntOne);
      end
    end else if (en) begin
      w_pre_d = r_pre + PreOne;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_pre   <= '0;
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_pre   <= w_pre_d;
      r_count <= w_count_d;
      r_wrap  <= w_wrap_d;
    end
  end

  assign count = r_count;
  assign tick  = w_tick;
  assign wrap  = r_wrap;

`ifdef COUNT_SNAPSHOT_EN
  logic             r_snap_s1;
  logic             r_snap_s2;
  logic [WIDTH-1:0] r_snap_val;
  logic             w_snap_rise;

  assign w_snap_rise = r_snap_s1 & ~r_snap_s2;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_snap_s1  <= 1'b0;
      r_snap_s2  <= 1'b0;
      r_snap_val <= '0;
    end else begin
      r_snap_s1 <= snap;
      r_snap_s2 <= r_snap_s1;
      if (w_soft_clr) begin
        r_snap_val <= '0;
      end else if (w_snap_rise) begin
        r_snap_val <= r_count;
      end
    end
  end

  assign snap_val = r_snap_val;
`endif

endmodule

// File: tb/tb_updown_counter_ctrl.sv
// Bench for updown_counter_ctrl: three instances (wrap/DIV=7, saturate/DIV=3, wrap/DIV=1)
// checked every cycle against an arithmetic reference model, plus vector table and corner cases.
module tb_updown_counter_ctrl;

  logic       clock = 1'b0;
  logic       rst_n;
  logic       en, dir, load;
  logic [1:0] vrst, vdir;
  logic [5:0] lv_val;
  logic       snap;

  logic [5:0] c0;
  logic [3:0] c1;
  logic [2:0] c2;
  logic       w0, w1, w2, t0, t1, t2;
  logic [5:0] sv0;
  logic [3:0] sv1;
  logic [2:0] sv2;

  always #5 clock = ~clock;

  updown_counter_ctrl #(.WIDTH(6), .DIV(7), .SAT(0)) u_dut (
    .clock(clock), .rst_n(rst_n), .en(en), .dir(dir), .vrst(vrst), .vdir(vdir),
    .load(load), .load_val(lv_val),
`ifdef COUNT_SNAPSHOT_EN
    .snap(snap), .snap_val(sv0),
`endif
    .count(c0), .tick(t0), .wrap(w0));

  updown_counter_ctrl #(.WIDTH(4), .DIV(3), .SAT(1)) u_sat (
    .clock(clock), .rst_n(rst_n), .en(en), .dir(dir), .vrst(vrst), .vdir(vdir),
    .load(load), .load_val(lv_val[3:0]),
`ifdef COUNT_SNAPSHOT_EN
    .snap(snap), .snap_val(sv1),
`endif
    .count(c1), .tick(t1), .wrap(w1));

  updown_counter_ctrl #(.WIDTH(3), .DIV(1), .SAT(0)) u_d1 (
    .clock(clock), .rst_n(rst_n), .en(en), .dir(dir), .vrst(vrst), .vdir(vdir),
    .load(load), .load_val(lv_val[2:0]),
`ifdef COUNT_SNAPSHOT_EN
    .snap(snap), .snap_val(sv2),
`endif
    .count(c2), .tick(t2), .wrap(w2));

`ifndef COUNT_SNAPSHOT_EN
  assign sv0 = '0;
  assign sv1 = '0;
  assign sv2 = '0;
`endif

  int d_c[3];
  int d_w[3];
  int d_t[3];
  always_comb begin
    d_c[0] = int'(c0); d_c[1] = int'(c1); d_c[2] = int'(c2);
    d_w[0] = int'(w0); d_w[1] = int'(w1); d_w[2] = int'(w2);
    d_t[0] = int'(t0); d_t[1] = int'(t1); d_t[2] = int'(t2);
  end

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state per instance.
  int m_c[3];
  int m_p[3];
  int m_w[3];

  function automatic int cfg_w(int i);
    case (i) 0: return 6; 1: return 4; default: return 3; endcase
  endfunction
  function automatic int cfg_div(int i);
    case (i) 0: return 7; 1: return 3; default: return 1; endcase
  endfunction
  function automatic bit cfg_sat(int i);
    return (i == 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_c[i] = 0; m_p[i] = 0; m_w[i] = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      int mx;
      bit up;
      mx = (1 << cfg_w(i)) - 1;
      up = dir || (vdir == 2'b11);
      if (vrst == 2'b11) begin
        m_c[i] = 0; m_p[i] = 0; m_w[i] = 0;
      end else if (load) begin
        m_c[i] = int'(lv_val) & mx; m_p[i] = 0; m_w[i] = 0;
      end else if (en && m_p[i] == cfg_div(i) - 1) begin
        int nxt;
        nxt = up ? m_c[i] + 1 : m_c[i] - 1;
        m_p[i] = 0;
        if (nxt < 0 || nxt > mx) begin
          m_w[i] = 1;
          if (!cfg_sat(i)) m_c[i] = (nxt < 0) ? mx : 0;
        end else begin
          m_w[i] = 0;
          m_c[i] = nxt;
        end
      end else begin
        m_w[i] = 0;
        if (en) m_p[i] = m_p[i] + 1;
      end
    end
  endtask

  task automatic check_model();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d_count", i), d_c[i], m_c[i]);
      chk($sformatf("u%0d_wrap", i), d_w[i], m_w[i]);
      chk($sformatf("u%0d_tick", i), d_t[i], int'(en && (m_p[i] == cfg_div(i) - 1)));
    end
  endtask

  // Inputs are stable between #1 after an edge and the next edge.
  task automatic step();
    @(negedge clock);
    check_model();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic set_in(input logic i_en, input logic i_dir, input logic [1:0] i_vrst,
                        input logic [1:0] i_vdir, input logic i_load, input logic [5:0] i_lv);
    en = i_en; dir = i_dir; vrst = i_vrst; vdir = i_vdir; load = i_load; lv_val = i_lv;
  endtask

  typedef struct {
    logic       en;
    logic       dir;
    logic [1:0] vrst;
    logic [1:0] vdir;
    logic       load;
    logic [5:0] lv;
    int         exp_dut;
    int         exp_sat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int pulses;
    int seen;

    vecs[0] = '{en: 0, dir: 1, vrst: 2'b00, vdir: 2'b00, load: 1, lv: 6'd20, exp_dut: 20, exp_sat: 4};
    vecs[1] = '{en: 0, dir: 1, vrst: 2'b11, vdir: 2'b00, load: 1, lv: 6'd9,  exp_dut: 0,  exp_sat: 0};
    vecs[2] = '{en: 0, dir: 1, vrst: 2'b00, vdir: 2'b00, load: 1, lv: 6'd63, exp_dut: 63, exp_sat: 15};
    vecs[3] = '{en: 0, dir: 1, vrst: 2'b01, vdir: 2'b00, load: 0, lv: 6'd0,  exp_dut: 63, exp_sat: 15};
    vecs[4] = '{en: 0, dir: 0, vrst: 2'b10, vdir: 2'b11, load: 0, lv: 6'd0,  exp_dut: 63, exp_sat: 15};
    vecs[5] = '{en: 1, dir: 0, vrst: 2'b00, vdir: 2'b00, load: 1, lv: 6'd33, exp_dut: 33, exp_sat: 1};
    vecs[6] = '{en: 0, dir: 0, vrst: 2'b00, vdir: 2'b00, load: 1, lv: 6'd5,  exp_dut: 5,  exp_sat: 5};
    vecs[7] = '{en: 0, dir: 0, vrst: 2'b11, vdir: 2'b00, load: 0, lv: 6'd7,  exp_dut: 0,  exp_sat: 0};

    rst_n = 1'b0;
    snap  = 1'b0;
    set_in(0, 0, 2'b00, 2'b00, 0, 6'd0);
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    chk("reset_count", d_c[0], 0);
    chk("reset_wrap", d_w[0], 0);
    chk("reset_tick", d_t[0], 0);

    // Count up from reset: first step DIV clocks after en rises.
    rst_n = 1'b1;
    set_in(1, 1, 2'b00, 2'b00, 0, 6'd0);
    seen = 0;
    for (int k = 0; k < 35; k++) begin
      step();
      seen |= d_w[0];
      if (k == 6) chk("first_step", d_c[0], 1);
    end
    chk("count_35", d_c[0], 5);
    chk("no_wrap_35", seen, 0);

    for (int v = 0; v < 8; v++) begin
      set_in(vecs[v].en, vecs[v].dir, vecs[v].vrst, vecs[v].vdir, vecs[v].load, vecs[v].lv);
      step();
      chk($sformatf("vec%0d_dut", v), d_c[0], vecs[v].exp_dut);
      chk($sformatf("vec%0d_sat", v), d_c[1], vecs[v].exp_sat);
      chk($sformatf("vec%0d_wrap", v), d_w[0], 0);
    end

    // Wrap-around up and down on the DIV=7 instance.
    set_in(1, 1, 2'b00, 2'b00, 1, 6'd63);
    step();
    load = 1'b0;
    repeat (7) step();
    chk("wrap_up_count", d_c[0], 0);
    chk("wrap_up_pulse", d_w[0], 1);
    set_in(1, 0, 2'b00, 2'b00, 1, 6'd0);
    step();
    chk("wrap_pulse_one_clk", d_w[0], 0);
    load = 1'b0;
    repeat (7) step();
    chk("wrap_dn_count", d_c[0], 63);
    chk("wrap_dn_pulse", d_w[0], 1);

    // Saturation on the SAT=1 instance: three blocked ticks, three pulses.
    set_in(1, 1, 2'b00, 2'b00, 1, 6'd63);
    step();
    load = 1'b0;
    pulses = 0;
    repeat (9) begin step(); pulses += d_w[1]; end
    chk("sat_hi_count", d_c[1], 15);
    chk("sat_hi_pulses", pulses, 3);
    set_in(1, 0, 2'b00, 2'b00, 1, 6'd0);
    step();
    load = 1'b0;
    pulses = 0;
    repeat (9) begin step(); pulses += d_w[1]; end
    chk("sat_lo_count", d_c[1], 0);
    chk("sat_lo_pulses", pulses, 3);

    // Debug direction override.
    set_in(1, 0, 2'b00, 2'b11, 1, 6'd10);
    step();
    load = 1'b0;
    repeat (7) step();
    chk("vdir_up", d_c[0], 11);
    vdir = 2'b10;
    repeat (7) step();
    chk("vdir_10_down", d_c[0], 10);

    // Asynchronous reset between edges, mid-period.
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_count", d_c[0], 0);
    chk("async_rst_wrap", d_w[0], 0);
    model_reset();
    rst_n = 1'b1;

    // Hold with en=0: prescaler must keep its phase.
    set_in(1, 1, 2'b00, 2'b00, 1, 6'd37);
    step();
    load = 1'b0;
    repeat (3) step();
    en = 1'b0;
    seen = 0;
    repeat (100) begin step(); seen |= d_t[0]; end
    chk("hold_count", d_c[0], 37);
    chk("hold_no_tick", seen, 0);
    en = 1'b1;
    repeat (4) step();
    chk("resume_count", d_c[0], 38);

`ifdef COUNT_SNAPSHOT_EN
    set_in(0, 1, 2'b00, 2'b00, 1, 6'd12);
    step();
    load = 1'b0;
    snap = 1'b1;
    step();
    step();
    chk("snap_val", int'(sv0), 12);
    snap = 1'b0;
    vrst = 2'b11;
    step();
    chk("snap_clr", int'(sv0), 0);
    vrst = 2'b00;
`endif

    for (int k = 0; k < 400; k++) begin
      en     = ($urandom_range(0, 3) != 0);
      dir    = 1'($urandom_range(0, 1));
      vrst   = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      vdir   = 2'($urandom_range(0, 3));
      load   = ($urandom_range(0, 19) == 0);
      lv_val = 6'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
